psram_req_arbiter: RTL

//  Shares the single serial PSRAM command engine between NUM_REQ byte-wide requesters.

---
 rtl/psram_pkg.sv | 25 ++
 rtl/psram_rr_pick.sv | 48 ++++
 rtl/psram_req_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// Shared opcodes and arbiter state encoding for the PSRAM request arbiter.
package psram_pkg;

    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDID  = 8'h9F;

    typedef enum logic [2:0] {
        ST_INIT_WAIT   = 3'd0,
        ST_RSTEN_ISSUE = 3'd1,
        ST_RSTEN_WAIT  = 3'd2,
        ST_RST_ISSUE   = 3'd3,
        ST_RST_WAIT    = 3'd4,
        ST_IDLE        = 3'd5,
        ST_ISSUE       = 3'd6,
        ST_WAIT        = 3'd7
    } arb_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/psram_rr_pick.sv
// Masked priority pick: first set request at or after ptr, wrapping.
// PSRAM_ARB_FIXED_PRIO_EN switches to plain lowest-index-wins.
module psram_rr_pick
    import psram_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W:0]       pos;

    always_comb begin
        dbl = '0;
        rot = '0;
        pos = '0;
        idx = '0;
        any = 1'b0;
`ifdef PSRAM_ARB_FIXED_PRIO_EN
        rot = req;
`else
        // rotate so that bit 0 of rot corresponds to requester ptr
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_REQ-1:0];
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
`ifdef PSRAM_ARB_FIXED_PRIO_EN
                pos = (IDX_W+1)'(i);
`else
                pos = {1'b0, ptr} + (IDX_W+1)'(i);
                if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                    pos = pos - (IDX_W+1)'(NUM_REQ);
                end
`endif
                idx = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/psram_req_arbiter.sv
// Shares one serial PSRAM command engine between NUM_REQ requesters and runs
// the power-up reset sequence. Build option: PSRAM_ARB_FIXED_PRIO_EN.
//
// state          | meaning
// ST_INIT_WAIT   | idle delay after reset before any command
// ST_RSTEN_ISSUE | present Reset-Enable (0x66) to engine
// ST_RSTEN_WAIT  | await engine completion of 0x66
// ST_RST_ISSUE   | present Reset (0x99) to engine
// ST_RST_WAIT    | await engine completion of 0x99, then init_done
// ST_IDLE        | arbitrate among pending requesters
// ST_ISSUE       | present granted Write/Read to engine
// ST_WAIT        | await completion or timeout, then respond
module psram_req_arbiter
    import psram_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 24,
    parameter int INIT_WAIT = 150,
    parameter int TIMEOUT   = 1023
) (
    input  logic                      sys_clk,
    input  logic                      sys_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [7:0]                rsp_rdata,
    output logic                      rsp_err,
    output logic                      init_done,
    output logic                      eng_cmd_valid,
    input  logic                      eng_cmd_ready,
    output logic [7:0]                eng_opcode,
    output logic                      eng_has_addr,
    output logic [ADDR_W-1:0]         eng_addr,
    output logic [7:0]                eng_wdata,
    input  logic                      eng_done,
    input  logic [7:0]                eng_rdata
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = int'(max_u(INIT_WAIT, TIMEOUT));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_WAIT - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUT - 1);

    arb_state_t          state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [IDX_W-1:0]    ptr, gnt_idx, pick_idx;
    logic                pick_any;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [7:0]          lat_wdata;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [7:0]          sel_wdata;
    logic                grant_load, accept, done_fire, tmo_fire, init_set;

    psram_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state <= ST_INIT_WAIT;
            cnt   <= INIT_LOAD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        grant_load    = 1'b0;
        accept        = 1'b0;
        done_fire     = 1'b0;
        tmo_fire      = 1'b0;
        init_set      = 1'b0;
        eng_cmd_valid = 1'b0;
        eng_opcode    = '0;
        eng_has_addr  = 1'b0;
        eng_addr      = '0;
        eng_wdata     = '0;
        req_ready     = '0;
        case (state)
            ST_INIT_WAIT: begin
                if (cnt == '0) state_nxt = ST_RSTEN_ISSUE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_RSTEN_ISSUE: begin
                eng_cmd_valid = 1'b1;
                eng_opcode    = OP_RSTEN;
                if (eng_cmd_ready) begin
                    state_nxt = ST_RSTEN_WAIT;
                    cnt_nxt   = TMO_LOAD;
                end
            end
            ST_RSTEN_WAIT: begin
                if (eng_done)        state_nxt = ST_RST_ISSUE;
                else if (cnt == '0)  state_nxt = ST_RSTEN_ISSUE;
                else                 cnt_nxt   = cnt - 1'b1;
            end
            ST_RST_ISSUE: begin
                eng_cmd_valid = 1'b1;
                eng_opcode    = OP_RST;
                if (eng_cmd_ready) begin
                    state_nxt = ST_RST_WAIT;
                    cnt_nxt   = TMO_LOAD;
                end
            end
            ST_RST_WAIT: begin
                if (eng_done) begin
                    state_nxt = ST_IDLE;
                    init_set  = 1'b1;
                end else if (cnt == '0) begin
                    // a lost init command restarts the whole reset pair
                    state_nxt = ST_RSTEN_ISSUE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_IDLE: begin
                if (init_done && pick_any) begin
                    state_nxt  = ST_ISSUE;
                    grant_load = 1'b1;
                end
            end
            ST_ISSUE: begin
                eng_cmd_valid = 1'b1;
                eng_opcode    = lat_we ? OP_WRITE : OP_READ;
                eng_has_addr  = 1'b1;
                eng_addr      = lat_addr;
                eng_wdata     = lat_we ? lat_wdata : 8'h00;
                if (eng_cmd_ready) begin
                    req_ready[gnt_idx] = 1'b1;
                    accept             = 1'b1;
                    state_nxt          = ST_WAIT;
                    cnt_nxt            = TMO_LOAD;
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    done_fire = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == '0) begin
                    tmo_fire  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_INIT_WAIT;
                cnt_nxt   = INIT_LOAD;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            ptr       <= '0;
            gnt_idx   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            init_done <= 1'b0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            if (grant_load) begin
                gnt_idx   <= pick_idx;
                lat_we    <= sel_we;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
            if (accept) begin
`ifdef PSRAM_ARB_FIXED_PRIO_EN
                ptr <= '0;
`else
                ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
            end
            if (init_set) begin
                init_done <= 1'b1;
            end
            if (done_fire) begin
                rsp_valid[gnt_idx] <= 1'b1;
                rsp_rdata          <= lat_we ? 8'h00 : eng_rdata;
            end
            if (tmo_fire) begin
                rsp_valid[gnt_idx] <= 1'b1;
                rsp_err            <= 1'b1;
                rsp_rdata          <= 8'h00;
            end
        end
    end

endmodule
